// File: rtl/rv32i_lsu.sv
// rv32i_lsu: single-outstanding RV32I load/store unit sequencing IDLE -> BUSY -> DONE.
// Define RV32I_LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them.
module rv32i_lsu (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_rd_addr,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wstrb,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_done,
    output logic        o_wb_we,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_misaligned
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    state_t      state;
    state_t      state_next;

    size_t       in_size;
    logic        accept;
    logic        trap;
    logic [3:0]  in_strb;
    logic [31:0] in_wdata;

    logic [31:0] addr_q;
    logic [1:0]  off_q;
    size_t       size_q;
    logic        unsigned_q;
    logic        load_q;
    logic [4:0]  rd_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic        mis_q;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Reserved encodings (011, 110, 111) fall through to word accesses.
    always_comb begin
        case (i_funct3)
            3'b000, 3'b100: in_size = SZ_B;
            3'b001, 3'b101: in_size = SZ_H;
            default:        in_size = SZ_W;
        endcase
    end

    always_comb begin
        accept = (state == IDLE) && i_valid && (i_is_load || i_is_store);
    end

`ifdef RV32I_LSU_MISALIGN_TRAP_EN
    always_comb begin
        trap = ((in_size == SZ_H) && i_addr[0]) ||
               ((in_size == SZ_W) && (i_addr[1:0] != 2'b00));
    end
`else
    always_comb begin
        trap = 1'b0;
    end
`endif

    // Without trapping, offending low bits are simply dropped by the lane math below.
    always_comb begin
        case (in_size)
            SZ_B: begin
                in_strb  = 4'b0001 << i_addr[1:0];
                in_wdata = {4{i_wdata[7:0]}};
            end
            SZ_H: begin
                in_strb  = 4'b0011 << {i_addr[1], 1'b0};
                in_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                in_strb  = 4'b1111;
                in_wdata = i_wdata;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = trap ? DONE : BUSY;
            BUSY:    if (i_mem_ack) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q     <= '0;
            off_q      <= '0;
            size_q     <= SZ_B;
            unsigned_q <= 1'b0;
            load_q     <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            mis_q      <= 1'b0;
        end else begin
            if (accept) begin
                addr_q     <= {i_addr[31:2], 2'b00};
                off_q      <= i_addr[1:0];
                size_q     <= in_size;
                unsigned_q <= i_funct3[2];
                load_q     <= i_is_load;
                rd_q       <= i_rd_addr;
                wdata_q    <= in_wdata;
                wstrb_q    <= i_is_load ? 4'b0000 : in_strb;
                mis_q      <= trap;
            end
            if ((state == BUSY) && i_mem_ack) begin
                rdata_q <= i_mem_rdata;
            end
        end
    end

    always_comb begin
        ld_byte = rdata_q[{off_q, 3'b000} +: 8];
        ld_half = rdata_q[{off_q[1], 4'b0000} +: 16];
        case (size_q)
            SZ_B:    ld_data = unsigned_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_H:    ld_data = unsigned_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = rdata_q;
        endcase
    end

    always_comb begin
        o_ready      = (state == IDLE);
        o_mem_req    = (state == BUSY);
        o_mem_we     = (state == BUSY) && !load_q;
        o_mem_addr   = addr_q;
        o_mem_wdata  = wdata_q;
        o_mem_wstrb  = wstrb_q;
        o_done       = (state == DONE);
        o_misaligned = (state == DONE) && mis_q;
        o_wb_we      = (state == DONE) && load_q && !mis_q;
        o_wb_rd      = (state == DONE) ? rd_q : 5'd0;
        o_wb_data    = ((state == DONE) && load_q && !mis_q) ? ld_data : 32'd0;
    end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Scoreboard bench for rv32i_lsu: byte-level reference memory, responding memory model, random ops.
// Expectations follow RV32I_LSU_MISALIGN_TRAP_EN when it is defined.
module tb_rv32i_lsu;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic        i_rst, i_valid, i_is_load, i_is_store;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_wdata;
    logic [4:0]  i_rd_addr;
    logic        o_ready, o_mem_req, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_done, o_wb_we;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_misaligned;

    rv32i_lsu dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_is_load(i_is_load), .i_is_store(i_is_store), .i_funct3(i_funct3),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_rd_addr(i_rd_addr),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_done(o_done), .o_wb_we(o_wb_we), .o_wb_rd(o_wb_rd),
        .o_wb_data(o_wb_data), .o_misaligned(o_misaligned)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
        logic        chk_data;
    } cpl_t;

    req_t req_q[$];
    cpl_t cpl_q[$];

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_bytes [64];
    logic [31:0] mem_words [16];
    int          force_delay = -1;
    logic        inject_ack = 1'b0;
    int          last_req_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    function automatic void preload(input int w, input logic [31:0] v);
        mem_words[w] = v;
        for (int k = 0; k < 4; k++) ref_bytes[w * 4 + k] = v[8 * k +: 8];
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // Reference: memory as 64 bytes, accesses as naturally aligned byte groups.
    function automatic void push_expect(input logic ld, input logic st, input logic [2:0] f3,
                                        input logic [31:0] addr, input logic [31:0] wd,
                                        input logic [4:0] rd);
        req_t        rq;
        cpl_t        cp;
        int          n, base;
        logic [31:0] val;
        logic [3:0]  strb;
        if (!(ld || st)) return;
        n    = size_of(f3);
        base = int'(addr[5:0]) - (int'(addr[5:0]) % n);
        cp.rd = rd;
        cp.mis = 1'b0;
        cp.chk_data = 1'b1;
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
        if ((int'(addr[1:0]) % n) != 0) begin
            cp.we = 1'b0;
            cp.data = '0;
            cp.mis = 1'b1;
            cp.chk_data = 1'b0;
            cpl_q.push_back(cp);
            return;
        end
`endif
        rq.addr = addr & 32'hFFFF_FFFC;
        if (ld) begin
            val = '0;
            for (int k = 0; k < n; k++) val = val | (32'(ref_bytes[base + k]) << (8 * k));
            if (n < 4 && !f3[2] && val[8 * n - 1]) val = val | (32'hFFFF_FFFF << (8 * n));
            rq.we = 1'b0;
            rq.wdata = '0;
            rq.wstrb = '0;
            cp.we = 1'b1;
            cp.data = val;
        end else begin
            strb = '0;
            for (int k = 0; k < n; k++) begin
                ref_bytes[base + k] = wd[8 * k +: 8];
                strb[(base + k) % 4] = 1'b1;
            end
            rq.we = 1'b1;
            rq.wstrb = strb;
            rq.wdata = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
            cp.we = 1'b0;
            cp.data = '0;
        end
        req_q.push_back(rq);
        cpl_q.push_back(cp);
    endfunction

    task automatic wait_ready();
        int n = 0;
        forever begin
            @(negedge i_clk);
            if (o_ready) break;
            n++;
            if (n > 100) begin
                check("ready_timeout", 32'(o_ready), 32'd1);
                break;
            end
        end
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        i_valid = 1'b1;
        i_is_load = ld;
        i_is_store = st;
        i_funct3 = f3;
        i_addr = addr;
        i_wdata = wd;
        i_rd_addr = rd;
    endtask

    // Returns at the falling edge just after the accepting rising edge.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        wait_ready();
        drive(ld, st, f3, addr, wd, rd);
        push_expect(ld, st, f3, addr, wd, rd);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_is_load = 1'b0;
        i_is_store = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        forever begin
            @(negedge i_clk);
            if (o_done) break;
            n++;
            if (n > 100) begin
                check("done_timeout", 32'(o_done), 32'd1);
                break;
            end
        end
    endtask

    // Memory responder: checks each request on its first cycle and its stability afterwards.
    initial begin
        bit   active = 1'b0;
        int   cnt = 0;
        int   delay = 0;
        req_t cur, exp_r, now_r;
        i_mem_ack = 1'b0;
        i_mem_rdata = '0;
        forever begin
            @(negedge i_clk);
            i_mem_ack = 1'b0;
            i_mem_rdata = '0;
            if (o_mem_req) begin
                now_r = {o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb};
                if (!active) begin
                    active = 1'b1;
                    cnt = 0;
                    delay = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
                    cur = now_r;
                    if (req_q.size() == 0) begin
                        check("unexpected_req", 32'(o_mem_req), 32'd0);
                    end else begin
                        exp_r = req_q.pop_front();
                        check("req_we", 32'(o_mem_we), 32'(exp_r.we));
                        check("req_addr", o_mem_addr, exp_r.addr);
                        if (exp_r.we) begin
                            check("req_wdata", o_mem_wdata, exp_r.wdata);
                            check("req_wstrb", 32'(o_mem_wstrb), 32'(exp_r.wstrb));
                        end
                    end
                end else begin
                    check("req_stable", 32'(now_r == cur), 32'd1);
                end
                cnt++;
                if (cnt > delay) begin
                    i_mem_ack = 1'b1;
                    i_mem_rdata = mem_words[o_mem_addr[5:2]];
                    if (o_mem_we) begin
                        for (int k = 0; k < 4; k++)
                            if (o_mem_wstrb[k]) mem_words[o_mem_addr[5:2]][8 * k +: 8] = o_mem_wdata[8 * k +: 8];
                    end
                    last_req_cycles = cnt;
                    active = 1'b0;
                end
            end else begin
                active = 1'b0;
                i_mem_ack = inject_ack;
                inject_ack = 1'b0;
            end
        end
    end

    // Completion monitor and per-cycle output invariants.
    initial begin
        cpl_t cp;
        forever begin
            @(negedge i_clk);
            check("invariants", {29'b0, o_mem_addr[1:0] != 2'b00,
                                 !o_done && (o_wb_we || o_misaligned),
                                 o_mem_req && (o_ready || o_done)}, 32'd0);
            if (o_done) begin
                if (cpl_q.size() == 0) begin
                    check("unexpected_done", 32'(o_done), 32'd0);
                end else begin
                    cp = cpl_q.pop_front();
                    check("wb_we", 32'(o_wb_we), 32'(cp.we));
                    check("wb_rd", 32'(o_wb_rd), 32'(cp.rd));
                    check("misaligned", 32'(o_misaligned), 32'(cp.mis));
                    if (cp.chk_data) check("wb_data", o_wb_data, cp.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          kind;
        logic        ld, st;
        logic [2:0]  f3;
        i_rst = 1'b1;
        i_valid = 1'b0;
        i_is_load = 1'b0;
        i_is_store = 1'b0;
        i_funct3 = '0;
        i_addr = '0;
        i_wdata = '0;
        i_rd_addr = '0;
        for (int w = 0; w < 16; w++) preload(w, $urandom);
        repeat (2) @(negedge i_clk);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_req", 32'(o_mem_req), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_addr", o_mem_addr, 32'd0);
        check("rst_wb_data", o_wb_data, 32'd0);
        i_rst = 1'b0;

        // LB from 0x1003 with same-cycle ack
        force_delay = 0;
        preload(0, 32'h80FF_0000);
        issue(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 5'd5);
        check("lb_req", 32'(o_mem_req), 32'd1);
        check("lb_busy_ready", 32'(o_ready), 32'd0);
        @(negedge i_clk);
        check("lb_done_timing", 32'(o_done), 32'd1);
        check("lb_data", o_wb_data, 32'hFFFF_FF80);
        check("lb_we", 32'(o_wb_we), 32'd1);

        // SH to 0x2002
        issue(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd7);
        check("sh_addr", o_mem_addr, 32'h0000_2000);
        check("sh_wstrb", 32'(o_mem_wstrb), 32'h0000_000C);
        check("sh_wdata", o_mem_wdata, 32'hABCD_ABCD);
        check("sh_we", 32'(o_mem_we), 32'd1);

        // LHU from 0x0002 with ack held back three cycles
        wait_ready();
        preload(0, 32'hBEEF_0000);
        force_delay = 3;
        issue(1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'd0, 5'd9);
        wait_done();
        check("lhu_data", o_wb_data, 32'h0000_BEEF);
        check("lhu_busy_cycles", 32'(last_req_cycles), 32'd4);

        // Reset while BUSY, then a stray ack in IDLE
        force_delay = 50;
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'd0, 5'd3);
        i_rst = 1'b1;
        void'(cpl_q.pop_back());
        @(negedge i_clk);
        i_rst = 1'b0;
        check("rstbusy_req", 32'(o_mem_req), 32'd0);
        check("rstbusy_ready", 32'(o_ready), 32'd1);
        #1 inject_ack = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        check("late_ack_done", 32'(o_done), 32'd0);
        check("late_ack_req", 32'(o_mem_req), 32'd0);
        @(negedge i_clk);
        check("late_ack_done2", 32'(o_done), 32'd0);
        force_delay = 0;

        // LW to 0x0001
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0001, 32'd0, 5'd4);
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
        check("lw_mis_done", 32'(o_done), 32'd1);
        check("lw_mis_flag", 32'(o_misaligned), 32'd1);
        check("lw_mis_noreq", 32'(o_mem_req), 32'd0);
`else
        check("lw_mis_req", 32'(o_mem_req), 32'd1);
        check("lw_mis_addr", o_mem_addr, 32'd0);
`endif

        // Valid with neither flag set is ignored
        wait_ready();
        drive(1'b0, 1'b0, 3'b010, 32'h0000_0020, 32'd0, 5'd1);
        @(negedge i_clk);
        i_valid = 1'b0;
        check("ignored_ready", 32'(o_ready), 32'd1);
        check("ignored_req", 32'(o_mem_req), 32'd0);

        // SB then LBU back to back with valid held high
        wait_ready();
        drive(1'b0, 1'b1, 3'b000, 32'h0000_0025, 32'h0000_00A5, 5'd2);
        push_expect(1'b0, 1'b1, 3'b000, 32'h0000_0025, 32'h0000_00A5, 5'd2);
        @(negedge i_clk);
        drive(1'b1, 1'b0, 3'b100, 32'h0000_0025, 32'd0, 5'd6);
        n = 1;
        while (!o_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        check("b2b_accept_gap", 32'(n), 32'd3);
        push_expect(1'b1, 1'b0, 3'b100, 32'h0000_0025, 32'd0, 5'd6);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_is_load = 1'b0;
        i_is_store = 1'b0;

        // Random mix
        force_delay = -1;
        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 19));
            ld = (kind == 1) || (kind >= 2 && kind <= 10);
            st = (kind == 1) || (kind >= 11);
            f3 = ld ? 3'($urandom) : 3'($urandom_range(0, 3));
            issue(ld, st, f3, $urandom, $urandom, 5'($urandom));
        end

        wait_ready();
        repeat (4) @(negedge i_clk);
        check("req_queue_empty", 32'(req_q.size()), 32'd0);
        check("cpl_queue_empty", 32'(cpl_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
